multi_axis_step_generator: RTL and testbench

//  Parametrised successor of the single-axis segment step generator. Drives NUM_AXES

---
 rtl/multi_axis_step_generator.sv | 171 +++++++++++++++++
 tb/tb_multi_axis_step_generator.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_axis_step_generator.sv
// -----------------------------------------------------------------------------
// multi_axis_step_generator
//
// Turns a stream of motion segments into NUM_AXES step/dir pin pairs. Each axis
// has a fractional phase accumulator. The accumulator advances by the segment's
// per-axis delta on every sample_tick, and its MSB is the step pin. A one-deep
// shadow register holds the next segment. When the active segment consumes its
// last tick, the shadow segment takes over on the same clock edge. This gives
// back-to-back segments with no idle tick and no phase discontinuity.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   sample_tick  one-cycle strobe; advances motion by one sample
//   seg_valid    a segment is offered on seg_delta/seg_dir/seg_count
//   seg_ready    the offered segment is taken when seg_valid & seg_ready
//   seg_delta    unsigned per-axis phase increment; axis i at [i*ACCU_WIDTH +: ACCU_WIDTH]
//   seg_dir      per-axis direction of the offered segment
//   seg_count    number of sample ticks in the offered segment (0 = drop)
//   step_out     per-axis step pin (accumulator MSB)
//   dir_out      per-axis direction of the active segment
//   busy         high while a segment is active (RUN)
//   seg_done     one-cycle pulse after the last tick of a segment
// -----------------------------------------------------------------------------
module multi_axis_step_generator #(
  parameter int NUM_AXES    = 4,
  parameter int ACCU_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sample_tick,
  input  logic                           seg_valid,
  output logic                           seg_ready,
  input  logic [NUM_AXES*ACCU_WIDTH-1:0] seg_delta,
  input  logic [NUM_AXES-1:0]            seg_dir,
  input  logic [COUNT_WIDTH-1:0]         seg_count,
  output logic [NUM_AXES-1:0]            step_out,
  output logic [NUM_AXES-1:0]            dir_out,
  output logic                           busy,
  output logic                           seg_done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                                r_state;
  logic                                  r_busy;
  logic                                  r_seg_done;
  logic [COUNT_WIDTH-1:0]                r_remaining;
  logic [NUM_AXES-1:0][ACCU_WIDTH-1:0]   r_acc;
  logic [NUM_AXES-1:0]                   r_dir;
  logic [NUM_AXES*ACCU_WIDTH-1:0]        r_delta;

  // Shadow (next) segment
  logic                                  r_shadow_valid;
  logic [NUM_AXES*ACCU_WIDTH-1:0]        r_shadow_delta;
  logic [NUM_AXES-1:0]                   r_shadow_dir;
  logic [COUNT_WIDTH-1:0]                r_shadow_count;

  logic                                  w_accept;
  logic                                  w_accept_live;
  logic                                  w_last_tick;
  logic                                  w_load_shadow;
  logic [NUM_AXES-1:0][ACCU_WIDTH-1:0]   w_acc_sum;

  // seg_ready depends only on registered state. There is no path from seg_valid.
  assign seg_ready     = ~r_shadow_valid;
  assign w_accept      = seg_valid & ~r_shadow_valid;
  // A zero-length segment is handshaken away without touching any state.
  assign w_accept_live = w_accept & (seg_count != '0);

  assign w_last_tick   = (r_state == S_RUN) & sample_tick &
                         (r_remaining == COUNT_WIDTH'(1));
  // The shadow drains either straight out of IDLE or on the last tick of the
  // active segment. The shadow is full in both cases, so seg_ready is low and no
  // new segment can be written in the same cycle.
  assign w_load_shadow = r_shadow_valid & ((r_state == S_IDLE) | w_last_tick);

  // Modulo-2^ACCU_WIDTH phase advance. The carry out is intentionally discarded.
  always_comb begin
    w_acc_sum = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      w_acc_sum[i] = r_acc[i] + r_delta[i*ACCU_WIDTH +: ACCU_WIDTH];
    end
  end

  always_comb begin
    step_out = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      step_out[i] = r_acc[i][ACCU_WIDTH-1];
    end
  end

  assign dir_out  = r_dir;
  assign busy     = r_busy;
  assign seg_done = r_seg_done;

  // ---- shadow register: control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_valid <= 1'b0;
    end else if (w_accept_live) begin
      r_shadow_valid <= 1'b1;
    end else if (w_load_shadow) begin
      r_shadow_valid <= 1'b0;
    end
  end

  // ---- shadow register: data (qualified by r_shadow_valid, no reset needed) ----
  always_ff @(posedge clk) begin
    if (w_accept_live) begin
      r_shadow_delta <= seg_delta;
      r_shadow_dir   <= seg_dir;
      r_shadow_count <= seg_count;
    end
  end

  // ---- active segment deltas (qualified by RUN) ----
  always_ff @(posedge clk) begin
    if (w_load_shadow) begin
      r_delta <= r_shadow_delta;
    end
  end

  // ---- segment sequencer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_seg_done  <= 1'b0;
      r_remaining <= '0;
      r_acc       <= '0;
      r_dir       <= '0;
    end else begin
      r_seg_done <= 1'b0;
      if (r_state == S_IDLE) begin
        // Start the shadow segment at once. A fresh segment starts from phase 0.
        if (r_shadow_valid) begin
          r_state     <= S_RUN;
          r_busy      <= 1'b1;
          r_remaining <= r_shadow_count;
          r_dir       <= r_shadow_dir;
          r_acc       <= '0;
        end
      end else if (sample_tick) begin
        if (r_remaining == COUNT_WIDTH'(1)) begin
          r_seg_done <= 1'b1;
          if (r_shadow_valid) begin
            // Zero-gap chaining. The last tick's phase is kept, so the next
            // segment continues the step train without a glitch.
            r_acc       <= w_acc_sum;
            r_remaining <= r_shadow_count;
            r_dir       <= r_shadow_dir;
          end else begin
            r_acc       <= '0;
            r_remaining <= '0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
          end
        end else begin
          r_acc       <= w_acc_sum;
          r_remaining <= r_remaining - COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_axis_step_generator.sv
module tb_multi_axis_step_generator;

  localparam int NA = 4;
  localparam int AW = 32;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic              seg_valid = 1'b0;
  logic              seg_ready;
  logic [NA*AW-1:0]  seg_delta = '0;
  logic [NA-1:0]     seg_dir = '0;
  logic [CW-1:0]     seg_count = '0;
  logic [NA-1:0]     step_out;
  logic [NA-1:0]     dir_out;
  logic              busy;
  logic              seg_done;

  multi_axis_step_generator #(.NUM_AXES(NA), .ACCU_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_delta(seg_delta), .seg_dir(seg_dir), .seg_count(seg_count),
    .step_out(step_out), .dir_out(dir_out), .busy(busy), .seg_done(seg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] rises;
    logic [3:0][7:0] togs;
    int              ticks;
    int              cyc;
  } obs_t;

  obs_t obs_q[$];
  obs_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state
  int              cyc = 0;
  int              done_cnt = 0;
  int              busy_rise = 0;
  int              busy_fall = 0;
  int              cur_ticks = 0;
  logic [3:0][7:0] cur_r = '0;
  logic [3:0][7:0] cur_t = '0;
  logic [NA-1:0]   prev_step = '0;
  logic            prev_busy = 1'b0;
  obs_t            mon_o;
  int              tick_ph = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Free-running tick: one sample_tick every 4 clocks
  initial forever begin
    @(posedge clk);
    #1;
    tick_ph = (tick_ph + 1) % 4;
    sample_tick = (tick_ph == 0);
  end

  // Per-segment observation: step edges and ticks spent busy, closed by seg_done
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cur_r = '0; cur_t = '0; cur_ticks = 0;
      prev_step = step_out; prev_busy = busy;
    end else begin
      for (int a = 0; a < NA; a++) begin
        if (step_out[a] !== prev_step[a]) begin
          cur_t[a] = cur_t[a] + 8'd1;
          if (step_out[a]) cur_r[a] = cur_r[a] + 8'd1;
        end
      end
      if (busy && !prev_busy) busy_rise = busy_rise + 1;
      if (!busy && prev_busy) busy_fall = busy_fall + 1;
      if (seg_done) begin
        mon_o.rises = cur_r; mon_o.togs = cur_t;
        mon_o.ticks = cur_ticks; mon_o.cyc = cyc;
        obs_q.push_back(mon_o);
        done_cnt = done_cnt + 1;
        cur_r = '0; cur_t = '0; cur_ticks = 0;
      end
      if (busy && sample_tick) cur_ticks = cur_ticks + 1;
      prev_step = step_out; prev_busy = busy;
    end
  end

  function automatic obs_t mk(input logic [3:0][7:0] r, input logic [3:0][7:0] t, input int ticks);
    obs_t o;
    o.rises = r; o.togs = t; o.ticks = ticks; o.cyc = 0;
    return o;
  endfunction

  // Offer one segment and hold it until the handshake completes
  task automatic send_seg(input logic [3:0][31:0] d, input logic [3:0] dir, input int cnt, output bit ok);
    int w;
    w = 0;
    @(posedge clk); #1;
    seg_delta = d; seg_dir = dir; seg_count = CW'(cnt); seg_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (seg_ready || w > 200) break;
      w++;
    end
    @(posedge clk); #1;
    seg_valid = 1'b0;
    ok = (w <= 200);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int w;
    w = 0;
    while (obs_q.size() < n && w < budget) begin
      @(negedge clk); #1;
      w++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (step_out !== 4'b0 || dir_out !== 4'b0 || busy !== 1'b0 || seg_done !== 1'b0 || seg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got step=%b dir=%b busy=%b done=%b ready=%b, expected 0000 0000 0 0 1",
               step_out, dir_out, busy, seg_done, seg_ready);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; obs_t e, o; int d0;
    d0 = done_cnt;
    exp_q.push_back(mk({8'd0, 8'd0, 8'd0, 8'd2}, {8'd0, 8'd0, 8'd0, 8'd4}, 8));
    send_seg({32'h0, 32'h0, 32'h0, 32'h4000_0000}, 4'b0001, 8, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (!ok || busy !== 1'b1 || dir_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_start: got accepted=%0b busy=%b dir=%b, expected 1 1 0001", ok, busy, dir_out);
    end
    wait_obs(1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL single_timeout: got %0d seg_done, expected 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.rises !== e.rises || o.togs !== e.togs || o.ticks != e.ticks) begin
        n_fail++;
        $display("FAIL single_seg: got rises=%h togs=%h ticks=%0d, expected rises=%h togs=%h ticks=%0d",
                 o.rises, o.togs, o.ticks, e.rises, e.togs, e.ticks);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || step_out !== 4'b0 || dir_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b step=%b dir0=%b, expected 0 0000 1", busy, step_out, dir_out[0]);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 1 || seg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulses: got %0d pulses done=%b, expected 1 pulse done=0", done_cnt - d0, seg_done);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2; obs_t a, b; int bf;
    bf = busy_fall;
    send_seg({32'h0, 32'h0, 32'h0, 32'h4000_0000}, 4'b0001, 3, ok);
    send_seg({32'h0, 32'h0, 32'h4000_0000, 32'h0}, 4'b0010, 3, ok2);
    wait_obs(1, 400, ok);
    n_checks++;
    if (!ok || !ok2) begin
      n_fail++; $display("FAIL b2b_first_timeout: got done=%0d accept2=%0b, expected 1 1", obs_q.size(), ok2);
    end
    a = mk({8'd0, 8'd0, 8'd0, 8'd1}, {8'd0, 8'd0, 8'd0, 8'd1}, 3);
    if (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      n_checks++;
      if (b.rises !== a.rises || b.togs !== a.togs || b.ticks != a.ticks) begin
        n_fail++;
        $display("FAIL b2b_seg_a: got rises=%h togs=%h ticks=%0d, expected rises=%h togs=%h ticks=%0d",
                 b.rises, b.togs, b.ticks, a.rises, a.togs, a.ticks);
      end
      a.cyc = b.cyc;
    end
    // Phase carried over: axis0 sits at 0xC000_0000 with zero delta, so it stays high
    n_checks++;
    if (busy !== 1'b1 || dir_out !== 4'b0010 || step_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_chain: got busy=%b dir=%b step0=%b, expected 1 0010 1", busy, dir_out, step_out[0]);
    end
    wait_obs(1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL b2b_second_timeout: got %0d seg_done, expected 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      n_checks++;
      if (b.rises !== {8'd0, 8'd0, 8'd1, 8'd0} || b.togs !== {8'd0, 8'd0, 8'd2, 8'd1} || b.ticks != 3) begin
        n_fail++;
        $display("FAIL b2b_seg_b: got rises=%h togs=%h ticks=%0d, expected rises=00000100 togs=00000201 ticks=3",
                 b.rises, b.togs, b.ticks);
      end
      n_checks++;
      if (b.cyc - a.cyc != 12) begin
        n_fail++; $display("FAIL b2b_done_spacing: got %0d cycles, expected 12", b.cyc - a.cyc);
      end
    end
    n_checks++;
    if (busy_fall - bf != 1) begin
      n_fail++; $display("FAIL b2b_busy_drops: got %0d busy falls, expected 1", busy_fall - bf);
    end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2, ok3, ok; obs_t e, o; int bf;
    bf = busy_fall;
    exp_q.push_back(mk({8'd0, 8'd1, 8'd0, 8'd0}, {8'd0, 8'd1, 8'd0, 8'd0}, 4));
    exp_q.push_back(mk({8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 2));
    exp_q.push_back(mk({8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd1, 8'd0, 8'd0}, 3));
    send_seg({32'h0, 32'h2000_0000, 32'h0, 32'h0}, 4'b0100, 4, ok1);
    send_seg({32'h0, 32'h2000_0000, 32'h0, 32'h0}, 4'b0100, 2, ok2);
    @(negedge clk);
    n_checks++;
    if (seg_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_low: got seg_ready=%b, expected 0", seg_ready);
    end
    send_seg({32'h0, 32'h2000_0000, 32'h0, 32'h0}, 4'b0100, 3, ok3);
    wait_obs(3, 600, ok);
    n_checks++;
    if (!(ok1 && ok2 && ok3 && ok)) begin
      n_fail++;
      $display("FAIL bp_timeout: got accepts=%0b%0b%0b done=%0d, expected 111 3", ok1, ok2, ok3, obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.rises !== e.rises || o.togs !== e.togs || o.ticks != e.ticks) begin
        n_fail++;
        $display("FAIL bp_seg: got rises=%h togs=%h ticks=%0d, expected rises=%h togs=%h ticks=%0d",
                 o.rises, o.togs, o.ticks, e.rises, e.togs, e.ticks);
      end
    end
    exp_q.delete();
    n_checks++;
    if (busy_fall - bf != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_busy: got falls=%0d busy=%b, expected 1 0", busy_fall - bf, busy);
    end
  endtask

  task automatic test_zero_count();
    bit ok; obs_t e, o; int d0, br; logic [NA-1:0] dir_before;
    d0 = done_cnt; br = busy_rise; dir_before = dir_out;
    send_seg({32'h0, 32'h0, 32'h0, 32'h4000_0000}, 4'b1111, 0, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || seg_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_idle_ready: got accepted=%0b ready=%b, expected 1 1", ok, seg_ready);
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if (busy_rise != br || done_cnt != d0 || dir_out !== dir_before || step_out !== 4'b0) begin
      n_fail++;
      $display("FAIL zero_idle_quiet: got rises=%0d dones=%0d dir=%b step=%b, expected 0 0 %b 0000",
               busy_rise - br, done_cnt - d0, dir_out, step_out, dir_before);
    end
    exp_q.push_back(mk({8'd1, 8'd0, 8'd0, 8'd0}, {8'd2, 8'd0, 8'd0, 8'd0}, 4));
    send_seg({32'h4000_0000, 32'h0, 32'h0, 32'h0}, 4'b1000, 4, ok);
    send_seg({32'h0, 32'h0, 32'h0, 32'h4000_0000}, 4'b0111, 0, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || seg_ready !== 1'b1 || dir_out !== 4'b1000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_run: got accepted=%0b ready=%b dir=%b busy=%b, expected 1 1 1000 1", ok, seg_ready, dir_out, busy);
    end
    wait_obs(1, 400, ok);
    repeat (20) @(negedge clk);
    n_checks++;
    if (!ok || done_cnt - d0 != 1 || busy_rise - br != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_run_done: got dones=%0d busy_rises=%0d busy=%b, expected 1 1 0", done_cnt - d0, busy_rise - br, busy);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.rises !== e.rises || o.togs !== e.togs || o.ticks != e.ticks) begin
        n_fail++;
        $display("FAIL zero_run_seg: got rises=%h togs=%h ticks=%0d, expected rises=%h togs=%h ticks=%0d",
                 o.rises, o.togs, o.ticks, e.rises, e.togs, e.ticks);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    bit ok; int w; obs_t e, o;
    send_seg({32'h0, 32'h0, 32'h0, 32'h4000_0000}, 4'b0101, 16, ok);
    w = 0;
    while (cur_ticks < 3 && w < 100) begin
      @(negedge clk); #1; w++;
    end
    @(negedge clk);
    n_checks++;
    if (!ok || step_out[0] !== 1'b1 || dir_out !== 4'b0101) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got accepted=%0b step0=%b dir=%b, expected 1 1 0101", ok, step_out[0], dir_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (step_out !== 4'b0 || dir_out !== 4'b0 || busy !== 1'b0 || seg_done !== 1'b0 || seg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_async: got step=%b dir=%b busy=%b done=%b ready=%b, expected 0000 0000 0 0 1",
               step_out, dir_out, busy, seg_done, seg_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back(mk({8'd0, 8'd0, 8'd0, 8'd1}, {8'd0, 8'd0, 8'd0, 8'd2}, 3));
    send_seg({32'h0, 32'h0, 32'h0, 32'h4000_0000}, 4'b0001, 3, ok);
    wait_obs(1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rst_after_timeout: got %0d seg_done, expected 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.rises !== e.rises || o.togs !== e.togs || o.ticks != e.ticks) begin
        n_fail++;
        $display("FAIL rst_after_seg: got rises=%h togs=%h ticks=%0d, expected rises=%h togs=%h ticks=%0d",
                 o.rises, o.togs, o.ticks, e.rises, e.togs, e.ticks);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_four_axes();
    bit ok; obs_t e, o;
    exp_q.push_back(mk({8'd0, 8'd4, 8'd2, 8'd1}, {8'd0, 8'd8, 8'd4, 8'd2}, 16));
    send_seg({32'h0, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000}, 4'b1010, 16, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || dir_out !== 4'b1010) begin
      n_fail++; $display("FAIL axes_dir: got accepted=%0b dir=%b, expected 1 1010", ok, dir_out);
    end
    wait_obs(1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL axes_timeout: got %0d seg_done, expected 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.rises !== e.rises || o.togs !== e.togs || o.ticks != e.ticks) begin
        n_fail++;
        $display("FAIL axes_seg: got rises=%h togs=%h ticks=%0d, expected rises=%h togs=%h ticks=%0d",
                 o.rises, o.togs, o.ticks, e.rises, e.togs, e.ticks);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1 ms, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero_count();
    test_async_reset();
    test_four_axes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
